// File: rtl/audio_pkg.sv
// Shared constants for the codec audio path: divider defaults, sample width and slot polarity.
package audio_pkg;

  localparam int unsigned MCLK_PER_BCLK_DEF = 6;
  localparam int unsigned BCLK_PER_CH_DEF   = 32;
  localparam int unsigned SAMPLE_W_DEF      = 16;

  localparam logic LRCK_LEFT = 1'b0;

endpackage

// File: rtl/audio_clk_div.sv
// Lock synchroniser plus BCLK/LRCK generation; emits a registered rise strobe and the bit slot count.
module audio_clk_div
  import audio_pkg::*;
#(
  parameter  int unsigned MCLK_PER_BCLK = MCLK_PER_BCLK_DEF,
  parameter  int unsigned BCLK_PER_CH   = BCLK_PER_CH_DEF,
  localparam int unsigned CW            = $clog2(BCLK_PER_CH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pll_locked,
  output logic          en,
  output logic          bclk,
  output logic          lrck,
  output logic          rise,
  output logic [CW-1:0] bit_cnt
);

  localparam int unsigned HALF = MCLK_PER_BCLK / 2;
  localparam int unsigned HW   = $clog2(HALF);

  logic [1:0]    sync_q, sync_d;
  logic [HW-1:0] half_cnt_q, half_cnt_d;
  logic          bclk_q, bclk_d;
  logic          lrck_q, lrck_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;

  // Divider chain; everything collapses to zero while lock is not synchronised.
  always_comb begin
    sync_d     = {sync_q[0], pll_locked};
    half_cnt_d = half_cnt_q;
    bclk_d     = bclk_q;
    lrck_d     = lrck_q;
    bit_cnt_d  = bit_cnt_q;
    rise_d     = 1'b0;
    if (!sync_q[1]) begin
      half_cnt_d = '0;
      bclk_d     = 1'b0;
      lrck_d     = 1'b0;
      bit_cnt_d  = '0;
    end else if (half_cnt_q == HW'(HALF - 1)) begin
      half_cnt_d = '0;
      bclk_d     = ~bclk_q;
      rise_d     = ~bclk_q;
      if (bclk_q) begin
        if (bit_cnt_q == CW'(BCLK_PER_CH - 1)) begin
          bit_cnt_d = '0;
          lrck_d    = ~lrck_q;
        end else begin
          bit_cnt_d = bit_cnt_q + CW'(1);
        end
      end
    end else begin
      half_cnt_d = half_cnt_q + HW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= '0;
      half_cnt_q <= '0;
      bclk_q     <= 1'b0;
      lrck_q     <= 1'b0;
      rise_q     <= 1'b0;
      bit_cnt_q  <= '0;
    end else begin
      sync_q     <= sync_d;
      half_cnt_q <= half_cnt_d;
      bclk_q     <= bclk_d;
      lrck_q     <= lrck_d;
      rise_q     <= rise_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

  assign en      = sync_q[1];
  assign bclk    = bclk_q;
  assign lrck    = lrck_q;
  assign rise    = rise_q;
  assign bit_cnt = bit_cnt_q;

endmodule

// File: rtl/audio_i2s_adc_rx.sv
// I2S master receiver for the codec ADC: deserialises ADCDAT and presents stereo pairs on valid/ready.
module audio_i2s_adc_rx
  import audio_pkg::*;
#(
  parameter int unsigned MCLK_PER_BCLK = MCLK_PER_BCLK_DEF,
  parameter int unsigned BCLK_PER_CH   = BCLK_PER_CH_DEF,
  parameter int unsigned SAMPLE_W      = SAMPLE_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pll_locked,
  output logic                aud_bclk,
  output logic                aud_adclrck,
  output logic                aud_daclrck,
  input  logic                aud_adcdat,
  output logic [SAMPLE_W-1:0] sample_left,
  output logic [SAMPLE_W-1:0] sample_right,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic                overrun
);

  localparam int unsigned CW = $clog2(BCLK_PER_CH);

  logic          en, bclk, lrck, rise;
  logic [CW-1:0] bit_cnt;

  audio_clk_div #(
    .MCLK_PER_BCLK (MCLK_PER_BCLK),
    .BCLK_PER_CH   (BCLK_PER_CH)
  ) u_clk_div (
    .clk        (clk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .en         (en),
    .bclk       (bclk),
    .lrck       (lrck),
    .rise       (rise),
    .bit_cnt    (bit_cnt)
  );

  logic                dat_q;
  logic [SAMPLE_W-1:0] shreg_q, shreg_d;
  logic [SAMPLE_W-1:0] left_hold_q, left_hold_d;
  logic [SAMPLE_W-1:0] left_q, left_d;
  logic [SAMPLE_W-1:0] right_q, right_d;
  logic                valid_q, valid_d;
  logic                overrun_q, overrun_d;
  logic                shift_c, word_done_c, pair_c;
  logic [SAMPLE_W-1:0] word_c;

  // Slot 0 is the I2S delay bit; only slots 1..SAMPLE_W are captured.
  always_comb begin
    shreg_d     = shreg_q;
    left_hold_d = left_hold_q;
    left_d      = left_q;
    right_d     = right_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q;
    shift_c     = en && rise && (bit_cnt >= CW'(1)) && (bit_cnt <= CW'(SAMPLE_W));
    word_c      = SAMPLE_W'({shreg_q, dat_q});
    word_done_c = shift_c && (bit_cnt == CW'(SAMPLE_W));
    pair_c      = word_done_c && (lrck != LRCK_LEFT);

    if (!en) begin
      shreg_d = '0;
    end else if (shift_c) begin
      shreg_d = word_c;
    end

    if (word_done_c && (lrck == LRCK_LEFT)) begin
      left_hold_d = word_c;
    end

    // A ready in the pair cycle is a transfer and a reload at once.
    if (pair_c) begin
      if (!valid_q || sample_ready) begin
        left_d  = left_hold_q;
        right_d = word_c;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (en && valid_q && sample_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dat_q       <= 1'b0;
      shreg_q     <= '0;
      left_hold_q <= '0;
      left_q      <= '0;
      right_q     <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      dat_q       <= aud_adcdat;
      shreg_q     <= shreg_d;
      left_hold_q <= left_hold_d;
      left_q      <= left_d;
      right_q     <= right_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign aud_bclk     = bclk;
  assign aud_adclrck  = lrck;
  assign aud_daclrck  = lrck;
  assign sample_left  = left_q;
  assign sample_right = right_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_audio_i2s_adc_rx.sv
// Bench for audio_i2s_adc_rx: codec model feeds frames, a monitor scoreboards delivered pairs.
module tb_audio_i2s_adc_rx;

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
    logic        dlv;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        pll_locked;
  logic        aud_adcdat = 1'b0;
  logic        sample_ready;
  logic        aud_bclk, aud_adclrck, aud_daclrck;
  logic [15:0] sample_left, sample_right;
  logic        sample_valid, overrun;

  int checks = 0;
  int failures = 0;
  int rx_count = 0;
  int lr_copy_bad = 0;

  frame_t drv_q[$];
  frame_t exp_q[$];

  audio_i2s_adc_rx dut (
    .clk          (clk),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .aud_bclk     (aud_bclk),
    .aud_adclrck  (aud_adclrck),
    .aud_daclrck  (aud_daclrck),
    .aud_adcdat   (aud_adcdat),
    .sample_left  (sample_left),
    .sample_right (sample_right),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out, got no event want event", name);
  endtask

  function automatic frame_t mk(input logic [15:0] l, input logic [15:0] r, input logic dlv);
    frame_t f;
    f.l = l;
    f.r = r;
    f.dlv = dlv;
    return f;
  endfunction

  // Codec model: changes ADCDAT after each BCLK fall; one-bit delay after LRCK edge, MSB first.
  logic        prev_bclk = 1'b0;
  logic        prev_lrck = 1'b0;
  logic        drv_lrck = 1'b0;
  int          drv_idx = 0;
  int          drv_tag = -1;
  int          pop_cnt = 0;
  frame_t      cur = '0;
  logic [15:0] w;

  always @(posedge clk) begin
    #1;
    if (!pll_locked) begin
      drv_idx = 0;
      aud_adcdat = 1'b0;
    end else if (prev_bclk && !aud_bclk) begin
      if (aud_adclrck != prev_lrck) drv_idx = 0;
      else drv_idx = drv_idx + 1;
      drv_lrck = aud_adclrck;
      if (drv_idx == 1 && !aud_adclrck) begin
        if (drv_q.size() > 0) begin
          cur = drv_q.pop_front();
          drv_tag = pop_cnt;
          pop_cnt++;
          if (cur.dlv) exp_q.push_back(cur);
        end else begin
          cur = '0;
          drv_tag = -1;
        end
      end
      if (drv_idx >= 1 && drv_idx <= 16) begin
        w = drv_lrck ? cur.r : cur.l;
        aud_adcdat = w[16-drv_idx];
      end else begin
        aud_adcdat = 1'b1;
      end
    end
    prev_bclk = aud_bclk;
    prev_lrck = aud_adclrck;
  end

  // Monitor: every transfer must match the oldest expected pair.
  frame_t e;
  always @(negedge clk) begin
    if (aud_daclrck !== aud_adclrck) lr_copy_bad++;
    if (!rst && sample_valid && sample_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pair_unexpected: got %h/%h want none", sample_left, sample_right);
      end else begin
        e = exp_q.pop_front();
        check("pair", {sample_left, sample_right}, {e.l, e.r});
      end
      rx_count++;
    end
  end

  task automatic wait_rx(input int n, input int budget, input string name);
    bit ok = 0;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk); #1;
      if (rx_count >= n) begin ok = 1; break; end
    end
    if (!ok) timeout(name);
  endtask

  task automatic wait_slot(input int tag, input logic lr, input int idx, input int budget,
                           input string name);
    bit ok = 0;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk); #2;
      if (drv_tag == tag && drv_lrck == lr && drv_idx == idx) begin ok = 1; break; end
    end
    if (!ok) timeout(name);
  endtask

  initial begin
    int bad, fr, nruns, run, bad_w, bad_al, last_rise, period, rises, width;
    int rise_c[3];
    logic pb, pl, pv, seen;
    bit ok;

    rst = 1'b1;
    pll_locked = 1'b0;
    sample_ready = 1'b1;
    for (int i = 0; i < 6; i++) drv_q.push_back(mk(16'hA5C3, 16'h5A3C, 1'b1));
    drv_q.push_back(mk(16'h1357, 16'h2468, 1'b1));
    drv_q.push_back(mk(16'h0F0F, 16'hF0F0, 1'b1));
    drv_q.push_back(mk(16'h1111, 16'h2222, 1'b1));
    drv_q.push_back(mk(16'h3333, 16'h4444, 1'b0));
    drv_q.push_back(mk(16'h8001, 16'h7FFE, 1'b1));
    drv_q.push_back(mk(16'hDEAD, 16'hBEEF, 1'b0));
    drv_q.push_back(mk(16'hCAFE, 16'h0001, 1'b1));

    // Reset state
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_bclk", aud_bclk, 0);
    check("rst_lrck", aud_adclrck, 0);
    check("rst_valid", sample_valid, 0);
    check("rst_overrun", overrun, 0);
    check("rst_samples", {sample_left, sample_right}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Test 1: no lock, nothing moves
    bad = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (aud_bclk || aud_adclrck || sample_valid || overrun) bad++;
    end
    check("idle_without_lock", bad, 0);

    // Test 2: lock, first rise, BCLK shape, LRCK period and alignment
    @(posedge clk); #1;
    pll_locked = 1'b1;
    fr = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (aud_bclk) begin fr = c; break; end
    end
    check("first_rise_within_5", (fr > 0 && fr <= 5), 1);
    pb = aud_bclk; pl = aud_adclrck; seen = 0; run = 1;
    nruns = 0; bad_w = 0; bad_al = 0; last_rise = -1; period = -1;
    for (int c = 0; c < 900; c++) begin
      @(negedge clk);
      if (aud_bclk == pb) run++;
      else begin
        if (seen && run != 3) bad_w++;
        if (seen) nruns++;
        seen = 1;
        run = 1;
      end
      if (aud_adclrck != pl && !(pb && !aud_bclk)) bad_al++;
      if (aud_adclrck && !pl) begin
        if (last_rise >= 0) period = c - last_rise;
        last_rise = c;
      end
      pb = aud_bclk;
      pl = aud_adclrck;
    end
    check("bclk_half_period_3", bad_w, 0);
    check("bclk_toggling", (nruns > 250), 1);
    check("lrck_period_384", period, 384);
    check("lrck_on_bclk_fall", bad_al, 0);

    // Test 3: one-clk valid pulses every 384 clk with ready held high
    rises = 0; bad_w = 0; width = 0; pv = sample_valid;
    for (int c = 0; c < 1400; c++) begin
      @(negedge clk);
      if (sample_valid && !pv) begin
        if (rises < 3) rise_c[rises] = c;
        rises++;
        width = 1;
      end else if (sample_valid) begin
        width++;
      end else if (pv) begin
        if (width != 1) bad_w++;
      end
      pv = sample_valid;
      if (rises >= 3 && !sample_valid) break;
    end
    check("valid_pulse_count", rises, 3);
    check("valid_pulse_width", bad_w, 0);
    check("valid_interval_a", rise_c[1] - rise_c[0], 384);
    check("valid_interval_b", rise_c[2] - rise_c[1], 384);
    wait_rx(6, 2000, "rx_tag5");

    // Test 5: ready pulse exactly in the pair cycle
    sample_ready = 1'b0;
    wait_slot(7, 1'b1, 16, 3000, "slot_tag7_right_lsb");
    repeat (3) @(posedge clk);
    #1 sample_ready = 1'b1;
    @(posedge clk);
    #1 sample_ready = 1'b0;
    @(negedge clk);
    check("reload_valid_stays", sample_valid, 1);
    check("reload_pair", {sample_left, sample_right}, 32'h0F0FF0F0);
    check("reload_no_overrun", overrun, 0);
    check("reload_transferred_prev", rx_count, 7);
    @(posedge clk); #1;
    sample_ready = 1'b1;
    wait_rx(8, 100, "rx_tag7");

    // Test 4: backpressure for two frames, second pair dropped
    sample_ready = 1'b0;
    ok = 0;
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      if (overrun) begin ok = 1; break; end
    end
    if (!ok) timeout("overrun_set");
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("hold_valid", sample_valid, 1);
    check("hold_pair", {sample_left, sample_right}, 32'h11112222);
    check("overrun_sticky", overrun, 1);
    @(posedge clk); #1;
    sample_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("ready_clears_valid", sample_valid, 0);
    wait_rx(10, 1500, "rx_tag10");

    // Test 6: lock lost mid right word, then relock
    wait_slot(11, 1'b1, 8, 1500, "slot_tag11_right_mid");
    pll_locked = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("unlock_bclk_low", aud_bclk, 0);
    check("unlock_lrck_low", aud_adclrck, 0);
    bad = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (sample_valid || aud_bclk || aud_adclrck) bad++;
    end
    check("unlock_quiet", bad, 0);
    @(posedge clk); #1;
    pll_locked = 1'b1;
    wait_rx(11, 1500, "rx_after_relock");
    sample_ready = 1'b0;
    repeat (5) @(posedge clk);
    check("overrun_kept", overrun, 1);
    check("all_expected_seen", exp_q.size(), 0);
    check("daclrck_copy", lr_copy_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
